serial_packer: RTL
==================

# serial_packer

Bit-serial to parallel packer sitting directly downstream of the PE bit-slot timing generator. It consumes the per-bit valid, word-start and word-last strobes plus the serial data bit, assembles LSB-first `BITWIDTH`-bit words, and pushes each completed word into a 2-entry output FIFO with a valid/ready handshake toward the parallel consumer. Framing errors and FIFO overflow are flagged with sticky status bits.

## Interface
- `BITWIDTH`, 8, bits per serial word; must be >= 2.
- `fast_clk`  in  1  bit clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bit_valid`  in  1  a serial bit is present this cycle; driven by the device data-valid.
- `word_start`  in  1  the current bit is bit 0 of a word; qualified by `bit_valid`.
- `word_last`  in  1  the current bit is bit `BITWIDTH-1`; qualified by `bit_valid`.
- `serial_in`  in  1  serial data bit, LSB first.
- `out_ready`  in  1  the consumer accepts `out_data` this cycle.
- `out_valid`  out  1  FIFO head holds a word.
- `out_data`  out  `BITWIDTH`  FIFO head word.
- `fill`  out  2  FIFO occupancy, 0..2.
- `frame_err`  out  1  sticky framing error.
- `overflow`  out  1  sticky word-dropped flag.
- `err_clr`  in  1  synchronous clear of `frame_err` and `overflow`.

## Operation
- Assembly: shift register `sr[BITWIDTH-1:0]` and bit counter `bcnt` of width clog2(BITWIDTH)+1.
  - On a cycle with `bit_valid` and `word_start`: `sr[0]` <= `serial_in` and `bcnt` <= 1.
  - On a cycle with `bit_valid` and no `word_start`: `sr[bcnt]` <= `serial_in` and `bcnt` <= `bcnt`+1.
  - Cycles without `bit_valid` change nothing: no capture, no count, strobes ignored.
- Word completion: a cycle with `bit_valid` and `word_last` completes a word.
  - The pushed word is `sr` with bit `BITWIDTH-1` replaced by `serial_in`, i.e. the current bit is included.
  - `bcnt` <= 0.
- Framing checks. Each one sets `frame_err` and follows the stated recovery.
  - `word_start` while `bcnt` != 0: restart the word and discard the partial word.
  - `word_last` while `bcnt` != `BITWIDTH-1`: discard the word, set `bcnt` <= 0, push nothing.
  - A bit with `bcnt` == 0 and no `word_start`: discard the bit; `bcnt` stays 0.
- FIFO: 2 entries, head/tail pointers and a registered count.
  - Push on word completion; pop when `out_valid` and `out_ready`.
  - Push and pop in the same cycle is legal at any fill; occupancy is unchanged.
  - Push when full with no pop drops the new word, sets `overflow` and leaves FIFO contents unchanged.
  - Pop when empty is ignored.
- Status: `err_clr` clears both sticky flags. A set event in the same cycle wins over `err_clr`.

## Timing
- Reset values: `sr` = 0, `bcnt` = 0, FIFO empty, `out_valid` = 0, `out_data` = 0, `fill` = 0, `frame_err` = 0, `overflow` = 0.
- Reset asserted mid-word or mid-handshake discards all state immediately (asynchronous). The first word after reset must begin with `word_start`.
- Latency: the last bit is captured at edge N; `out_valid` = 1 and `out_data` is valid after edge N, with no combinational path from serial inputs to outputs.
- `out_data`, `out_valid` and `fill` are registered or decoded from registered FIFO state only.
- `out_valid` is high whenever `fill` != 0. `out_data` holds stable while `out_valid` is high and `out_ready` is low.
- Throughput: one word per `BITWIDTH` valid bits. Bit valid may be gapped arbitrarily without corrupting assembly.
- Pop at edge M: the next entry, if any, appears after edge M; `fill` decrements at the same edge.
- Flags assert the edge after the offending cycle.

## Test plan
- BITWIDTH=8, continuous `bit_valid`, send 0xA5 LSB-first with start/last strobes, `out_ready`=1 -> `out_valid` high for exactly one cycle, the cycle after bit 7; `out_data`=0xA5; `fill` returns to 0.
- Same word with `bit_valid` low for 3 cycles between bits 3 and 4 -> `out_data`=0xA5, no flags, `out_valid` the cycle after bit 7.
- `out_ready`=0, send 0x01, 0x02, 0x03 -> `fill`=2, head 0x01, `overflow`=1 after the third word; then hold `out_ready`=1 -> pops 0x01 then 0x02, `fill`=0.
- `fill`=2 with `out_ready`=1 in the same cycle as 0x7E completes -> no overflow, `fill` stays 2, pop order preserved, 0x7E last.
- `word_start` after 5 bits, then a clean 0x3C -> `frame_err`=1, only 0x3C is output. Then `err_clr` -> `frame_err`=0.
- Reset pulsed after 4 bits of a word with `fill`=1 -> all outputs 0 after the reset edge; the next clean word 0xFF outputs correctly.

Source files
------------

// File: rtl/serial_packer_if.sv
// Serial bit-slot strobes in, parallel word handshake out, plus sticky status.
// The slave modport is the packer's view; the master modport is the driver/consumer's view.
interface serial_packer_if #(
  parameter int BITWIDTH = 8
);
  logic                bit_valid;
  logic                word_start;
  logic                word_last;
  logic                serial_in;
  logic                out_ready;
  logic                err_clr;
  logic                out_valid;
  logic [BITWIDTH-1:0] out_data;
  logic [1:0]          fill;
  logic                frame_err;
  logic                overflow;

  modport master (
    output bit_valid, word_start, word_last, serial_in, out_ready, err_clr,
    input  out_valid, out_data, fill, frame_err, overflow
  );

  modport slave (
    input  bit_valid, word_start, word_last, serial_in, out_ready, err_clr,
    output out_valid, out_data, fill, frame_err, overflow
  );
endinterface

// File: rtl/serial_packer.sv
// Bit-serial to parallel packer: assembles LSB-first words from the bit-slot strobes
// and queues them in a 2-entry FIFO, flagging framing errors and dropped words.
module serial_packer #(
  parameter int BITWIDTH = 8
) (
  input  logic            fast_clk,
  input  logic            rst,
  serial_packer_if.slave  bus
);

  localparam int             CW       = $clog2(BITWIDTH) + 1;
  localparam logic [CW-1:0]  LAST_POS = CW'(BITWIDTH - 1);
  localparam logic [CW-1:0]  OVER_POS = CW'(BITWIDTH);

  logic [BITWIDTH-1:0] sr;
  logic [BITWIDTH-1:0] sr_next;
  logic [CW-1:0]       bcnt;
  logic [CW-1:0]       bcnt_next;
  logic                start_err;
  logic                last_err;
  logic                orphan_err;
  logic                word_done;
  logic [BITWIDTH-1:0] done_word;

  logic [BITWIDTH-1:0] mem [2];
  logic                head;
  logic                tail;
  logic [1:0]          count;
  logic                pop;
  logic                push;
  logic                drop;
  logic                full;
  logic                frame_set;
  logic                frame_err_q;
  logic                overflow_q;

  // A start strobe defines its own bit position, so start+last together is always a short word.
  always_comb begin
    sr_next    = sr;
    bcnt_next  = bcnt;
    start_err  = 1'b0;
    last_err   = 1'b0;
    orphan_err = 1'b0;
    word_done  = 1'b0;
    done_word  = {bus.serial_in, sr[BITWIDTH-2:0]};
    if (bus.bit_valid) begin
      if (bus.word_start) begin
        start_err  = (bcnt != '0);
        sr_next[0] = bus.serial_in;
        if (bus.word_last) begin
          last_err  = 1'b1;
          bcnt_next = '0;
        end else begin
          bcnt_next = CW'(1);
        end
      end else if (bcnt == '0) begin
        orphan_err = 1'b1;
      end else if (bus.word_last) begin
        bcnt_next = '0;
        if (bcnt == LAST_POS) begin
          word_done = 1'b1;
        end else begin
          last_err = 1'b1;
        end
      end else begin
        for (int i = 0; i < BITWIDTH; i++) begin
          if (bcnt == CW'(i)) begin
            sr_next[i] = bus.serial_in;
          end
        end
        // Over-long words park the counter past the last slot so the missing last strobe is caught.
        if (bcnt != OVER_POS) begin
          bcnt_next = bcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      bcnt <= '0;
    end else begin
      sr   <= sr_next;
      bcnt <= bcnt_next;
    end
  end

  assign full      = (count == 2'd2);
  assign pop       = (count != 2'd0) && bus.out_ready;
  assign push      = word_done && (!full || pop);
  assign drop      = word_done && full && !pop;
  assign frame_set = start_err || last_err || orphan_err;

  // When full, tail aliases head, so a simultaneous push overwrites exactly the slot being popped.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= done_word;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (frame_set) begin
        frame_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err_q <= 1'b0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = (count != 2'd0) ? mem[head] : '0;
  assign bus.fill      = count;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;

endmodule
